// File: rtl/mult_share_arbiter.sv
// Round-robin share of one pipelined DWxDW multiplier; accept->res_valid = 1+MULT_LAT cycles, hold freezes all, no result backpressure.
// Optional per-requester grant / conflict counters under MULT_SHARE_STATS_EN.
module mult_share_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ID_W     = 2,
   parameter int MULT_LAT = 1,
   parameter int DW       = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  hold,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*DW-1:0] req_a,
   input  logic [NUM_REQ*DW-1:0] req_b,
   output logic                  mult_ce,
   output logic [DW-1:0]         mult_a,
   output logic [DW-1:0]         mult_b,
   input  logic [2*DW-1:0]       mult_p,
   output logic                  res_valid,
   output logic [ID_W-1:0]       res_id,
   output logic [2*DW-1:0]       res_p,
   output logic                  busy
`ifdef MULT_SHARE_STATS_EN
   ,
   input  logic                  stat_clr,
   output logic [NUM_REQ*16-1:0] stat_grant,
   output logic [15:0]           stat_conf
`endif
);

   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
   } tag_t;

   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [DW-1:0]   mult_a_q, mult_a_d, mult_b_q, mult_b_d;
   tag_t            tag_q [MULT_LAT+1];
   tag_t            tag_d [MULT_LAT+1];
   logic            found;
   logic [ID_W-1:0] win_id;
   logic            xfer;

   // Search starts just past the last winner so every requester gets a turn.
   always_comb begin
      int idx;
      found  = 1'b0;
      win_id = '0;
      idx    = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            win_id = ID_W'(idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (found && !hold && !rst)
         req_ready[win_id] = 1'b1;
      xfer = |(req_valid & req_ready);
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      mult_a_d = mult_a_q;
      mult_b_d = mult_b_q;
      tag_d    = tag_q;
      if (xfer) begin
         rr_ptr_d = win_id;
         mult_a_d = req_a[win_id*DW +: DW];
         mult_b_d = req_b[win_id*DW +: DW];
      end
      if (!hold) begin
         tag_d[0].vld = xfer;
         tag_d[0].id  = xfer ? win_id : '0;
         for (int i = 1; i <= MULT_LAT; i++)
            tag_d[i] = tag_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= ID_W'(NUM_REQ - 1);
         mult_a_q <= '0;
         mult_b_q <= '0;
         for (int i = 0; i <= MULT_LAT; i++)
            tag_q[i] <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         mult_a_q <= mult_a_d;
         mult_b_q <= mult_b_d;
         tag_q    <= tag_d;
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i <= MULT_LAT; i++)
         busy = busy | tag_q[i].vld;
      busy      = busy & ~rst;
      mult_ce   = ~hold & ~rst;
      mult_a    = mult_a_q;
      mult_b    = mult_b_q;
      res_valid = tag_q[MULT_LAT].vld & ~hold & ~rst;
      res_id    = tag_q[MULT_LAT].id;
      res_p     = mult_p;
   end

`ifdef MULT_SHARE_STATS_EN
   logic [15:0] gcnt_q [NUM_REQ];
   logic [15:0] gcnt_d [NUM_REQ];
   logic [15:0] conf_q, conf_d;

   // Clear beats a same-cycle increment; counters stick at all-ones.
   always_comb begin
      int nv;
      nv = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         nv = nv + int'(req_valid[i]);
         gcnt_d[i] = gcnt_q[i];
         if (stat_clr)
            gcnt_d[i] = '0;
         else if (req_valid[i] && req_ready[i] && gcnt_q[i] != 16'hFFFF)
            gcnt_d[i] = gcnt_q[i] + 16'd1;
      end
      conf_d = conf_q;
      if (stat_clr)
         conf_d = '0;
      else if (nv >= 2 && !hold && conf_q != 16'hFFFF)
         conf_d = conf_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         conf_q <= '0;
         for (int i = 0; i < NUM_REQ; i++)
            gcnt_q[i] <= '0;
      end else begin
         conf_q <= conf_d;
         gcnt_q <= gcnt_d;
      end
   end

   always_comb begin
      stat_grant = '0;
      for (int i = 0; i < NUM_REQ; i++)
         stat_grant[i*16 +: 16] = gcnt_q[i];
      stat_conf = conf_q;
   end
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural pipelined multiplier on mult_a/mult_b.
// Build with -DMULT_SHARE_STATS_EN to exercise the counters; MULT_LAT may be overridden.
module tb_mult_share_arbiter;
   parameter int MULT_LAT = 1;
   localparam int NR = 4;
   localparam int IW = 2;
   localparam int DW = 9;

   logic              clk = 1'b0;
   logic              rst, hold;
   logic [NR-1:0]     req_valid, req_ready;
   logic [NR*DW-1:0]  req_a, req_b;
   logic              mult_ce;
   logic [DW-1:0]     mult_a, mult_b;
   logic [2*DW-1:0]   mult_p;
   logic              res_valid;
   logic [IW-1:0]     res_id;
   logic [2*DW-1:0]   res_p;
   logic              busy;
`ifdef MULT_SHARE_STATS_EN
   logic              stat_clr;
   logic [NR*16-1:0]  stat_grant;
   logic [15:0]       stat_conf;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc;
   int exp_p [4] = '{12, 30, 56, 1022};

   logic [IW-1:0]   rid_q [$];
   logic [2*DW-1:0] rp_q  [$];
   int              rcyc_q[$];
   logic [2*DW-1:0] mp [MULT_LAT];

   always #5 clk = ~clk;

   mult_share_arbiter #(.NUM_REQ(NR), .ID_W(IW), .MULT_LAT(MULT_LAT), .DW(DW)) dut (
      .clk(clk), .rst(rst), .hold(hold),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .mult_ce(mult_ce), .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
      .res_valid(res_valid), .res_id(res_id), .res_p(res_p), .busy(busy)
`ifdef MULT_SHARE_STATS_EN
      , .stat_clr(stat_clr), .stat_grant(stat_grant), .stat_conf(stat_conf)
`endif
   );

   // External multiplier: MULT_LAT registers, advancing only when mult_ce.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MULT_LAT; i++) mp[i] <= '0;
      end else if (mult_ce) begin
         mp[0] <= {9'b0, mult_a} * {9'b0, mult_b};
         for (int i = 1; i < MULT_LAT; i++) mp[i] <= mp[i-1];
      end
   end
   assign mult_p = mp[MULT_LAT-1];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (res_valid) begin
         rid_q.push_back(res_id);
         rp_q.push_back(res_p);
         rcyc_q.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ab(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
      req_a[i*DW +: DW] = a;
      req_b[i*DW +: DW] = b;
   endtask

   task automatic clear_q();
      rid_q.delete();
      rp_q.delete();
      rcyc_q.delete();
   endtask

   initial begin
      rst = 1'b1; hold = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
`ifdef MULT_SHARE_STATS_EN
      stat_clr = 1'b0;
`endif
      tick(); tick(); #1;
      check("rst_ready", 32'(req_ready), 0);
      check("rst_ce", 32'(mult_ce), 0);
      check("rst_a", 32'(mult_a), 0);
      check("rst_b", 32'(mult_b), 0);
      check("rst_res_valid", 32'(res_valid), 0);
      check("rst_res_id", 32'(res_id), 0);
      check("rst_busy", 32'(busy), 0);

      // Single max-value product from requester 0
      tick(); rst = 1'b0; set_ab(0, 9'd511, 9'd511); req_valid = 4'b0001; #1;
      check("t1_ready", 32'(req_ready), 32'b0001);
      for (int k = 1; k <= MULT_LAT + 1; k++) begin
         tick(); req_valid = '0; #1;
         check("t1_res_valid", 32'(res_valid), (k == MULT_LAT + 1) ? 1 : 0);
         if (k == 1) check("t1_busy", 32'(busy), 1);
      end
      check("t1_res_id", 32'(res_id), 0);
      check("t1_res_p", 32'(res_p), 261121);
      tick(); #1;
      check("t1_idle_busy", 32'(busy), 0);
      check("t1_idle_vld", 32'(res_valid), 0);

      // All four valid continuously from reset
      rst = 1'b1;
      set_ab(0, 3, 4); set_ab(1, 5, 6); set_ab(2, 7, 8); set_ab(3, 511, 2);
      req_valid = 4'b1111; #1;
      check("t2_rst_ready", 32'(req_ready), 0);
      tick(); rst = 1'b0; clear_q(); #1;
      for (int k = 0; k < 8; k++) begin
         check("t2_grant", 32'(req_ready), 32'(1) << (k % 4));
         tick();
         if (k == 7) req_valid = '0;
         #1;
      end
      repeat (MULT_LAT + 2) tick();
      check("t2_count", rid_q.size(), 8);
      for (int k = 0; k < 8 && k < rid_q.size(); k++) begin
         check("t2_id", 32'(rid_q[k]), k % 4);
         check("t2_p", 32'(rp_q[k]), exp_p[k % 4]);
         if (k > 0) check("t2_back2back", rcyc_q[k] - rcyc_q[k-1], 1);
      end

      // Round-robin from rr_ptr=1 with req1 and req3 competing
      req_valid = 4'b0010; #1;
      check("t3_setup", 32'(req_ready), 32'b0010);
      tick(); req_valid = 4'b1010; #1;
      check("t3_first", 32'(req_ready), 32'b1000);
      tick(); req_valid = 4'b0010; #1;
      check("t3_second", 32'(req_ready), 32'b0010);
      tick(); req_valid = 4'b0110; #1;
      check("t3_ptr_is_1", 32'(req_ready), 32'b0100);
      tick(); req_valid = '0;
      repeat (MULT_LAT + 3) tick();

      // Back-to-back stream with a 3-cycle hold in the middle
      clear_q(); acc = 0;
      for (int c = 0; c < 9; c++) begin
         hold = (c >= 3 && c < 6);
         req_valid = 4'b0001;
         set_ab(0, 9'(10 + acc), 9'd3);
         #1;
         check("t4_ready", 32'(req_ready), hold ? 0 : 1);
         if (hold) begin
            check("t4_ce", 32'(mult_ce), 0);
            check("t4_res_valid", 32'(res_valid), 0);
            check("t4_a_frozen", 32'(mult_a), 12);
         end else begin
            acc++;
         end
         tick();
      end
      hold = 1'b0; req_valid = '0;
      repeat (MULT_LAT + 3) tick();
      check("t4_count", rid_q.size(), 6);
      for (int k = 0; k < 6 && k < rp_q.size(); k++) begin
         check("t4_id", 32'(rid_q[k]), 0);
         check("t4_p", 32'(rp_q[k]), (10 + k) * 3);
      end

      // Reset with two products in flight
      clear_q();
      set_ab(1, 20, 20); req_valid = 4'b0010; #1;
      check("t5_issue0", 32'(req_ready), 32'b0010);
      tick(); set_ab(1, 21, 21); #1;
      check("t5_issue1", 32'(req_ready), 32'b0010);
      tick(); rst = 1'b1; req_valid = '0; #1;
      check("t5_rst_vld", 32'(res_valid), 0);
      check("t5_rst_busy", 32'(busy), 0);
      tick(); rst = 1'b0; set_ab(0, 2, 3); req_valid = 4'b1111; #1;
      check("t5_busy", 32'(busy), 0);
      check("t5_vld", 32'(res_valid), 0);
      check("t5_grant0", 32'(req_ready), 32'b0001);
      tick(); req_valid = '0;
      repeat (MULT_LAT + 2) tick();
      check("t5_count", rid_q.size(), 1);
      if (rid_q.size() > 0) begin
         check("t5_id", 32'(rid_q[0]), 0);
         check("t5_p", 32'(rp_q[0]), 6);
      end

`ifdef MULT_SHARE_STATS_EN
      stat_clr = 1'b1;
      tick(); stat_clr = 1'b0; #1;
      check("t6_clr_conf", 32'(stat_conf), 0);
      check("t6_clr_g0", 32'(stat_grant[0 +: 16]), 0);
      set_ab(2, 1, 1); req_valid = 4'b0100;
      repeat (10) tick();
      req_valid = 4'b0011;
      repeat (4) tick();
      req_valid = '0; #1;
      check("t6_g2", 32'(stat_grant[2*16 +: 16]), 10);
      check("t6_g0", 32'(stat_grant[0 +: 16]), 2);
      check("t6_g1", 32'(stat_grant[16 +: 16]), 2);
      check("t6_g3", 32'(stat_grant[3*16 +: 16]), 0);
      check("t6_conf", 32'(stat_conf), 4);
      stat_clr = 1'b1; req_valid = 4'b0011;
      tick(); stat_clr = 1'b0; req_valid = '0; #1;
      check("t6_clr2_g2", 32'(stat_grant[2*16 +: 16]), 0);
      check("t6_clr2_g0", 32'(stat_grant[0 +: 16]), 0);
      check("t6_clr2_conf", 32'(stat_conf), 0);
      repeat (MULT_LAT + 3) tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
